// File: rtl/bcast_logic_arb.sv
// Round-robin arbiter and sequencer sharing one broadcast logic unit (A op {WIDTH{B}}) between two requesters.
// Optional stall counter on wait_cnt is built only when BCAST_LOGIC_WAIT_CNT_EN is defined.
module bcast_logic_arb #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic [WIDTH-1:0] a0,
    input  logic             b0,
    input  logic [1:0]       op0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a1,
    input  logic             b1,
    input  logic [1:0]       op1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             busy,
    output logic             res_vld,
    output logic             res_id,
    output logic [WIDTH-1:0] res,
    input  logic             res_ack,
    output logic [15:0]      wait_cnt
);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t           state_reg, state_next;
    logic             last_gnt_reg;
    logic             owner_reg;
    logic [WIDTH-1:0] cap_a_reg;
    logic             cap_b_reg;
    logic [1:0]       cap_op_reg;
    logic [WIDTH-1:0] res_reg;
    logic             res_id_reg;
    logic [WIDTH-1:0] alu_next;
    logic             gnt0_next, gnt1_next;

    always_comb begin
        state_next = state_reg;
        gnt0_next  = 1'b0;
        gnt1_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                // On a tie, the requester that did not win last time goes first.
                if (req0 && req1) begin
                    gnt0_next = last_gnt_reg;
                    gnt1_next = ~last_gnt_reg;
                end else begin
                    gnt0_next = req0;
                    gnt1_next = req1;
                end
                if (req0 || req1) state_next = EXEC;
            end
            EXEC:    state_next = DONE;
            DONE:    if (res_ack) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        alu_next = cap_a_reg;
        case (cap_op_reg)
            2'b00:   alu_next = cap_a_reg | {WIDTH{cap_b_reg}};
            2'b01:   alu_next = cap_a_reg & {WIDTH{cap_b_reg}};
            2'b10:   alu_next = cap_a_reg ^ {WIDTH{cap_b_reg}};
            default: alu_next = cap_a_reg;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            last_gnt_reg <= 1'b1;
            owner_reg    <= 1'b0;
            cap_a_reg    <= '0;
            cap_b_reg    <= 1'b0;
            cap_op_reg   <= 2'b00;
            res_reg      <= '0;
            res_id_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (gnt0_next) begin
                cap_a_reg    <= a0;
                cap_b_reg    <= b0;
                cap_op_reg   <= op0;
                owner_reg    <= 1'b0;
                last_gnt_reg <= 1'b0;
            end else if (gnt1_next) begin
                cap_a_reg    <= a1;
                cap_b_reg    <= b1;
                cap_op_reg   <= op1;
                owner_reg    <= 1'b1;
                last_gnt_reg <= 1'b1;
            end
            if (state_reg == EXEC) begin
                res_reg    <= alu_next;
                res_id_reg <= owner_reg;
            end
        end
    end

    // Grants are masked by reset so they drop the moment rst_n falls.
    assign gnt0    = gnt0_next & rst_n;
    assign gnt1    = gnt1_next & rst_n;
    assign busy    = (state_reg != IDLE);
    assign res_vld = (state_reg == DONE);
    assign res_id  = res_id_reg;
    assign res     = res_reg;

`ifdef BCAST_LOGIC_WAIT_CNT_EN
    logic [15:0] wait_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_reg <= 16'h0000;
        end else if (state_reg == DONE && !res_ack && wait_cnt_reg != 16'hFFFF) begin
            wait_cnt_reg <= wait_cnt_reg + 16'h0001;
        end
    end

    assign wait_cnt = wait_cnt_reg;
`else
    assign wait_cnt = 16'h0000;
`endif

endmodule

// File: doc/bcast_logic_arb.md
Name: bcast_logic_arb

Overview:
- Two-requester round-robin arbiter and sequencer for one shared WIDTH-bit broadcast logic unit.
- The unit computes A op {WIDTH{B}}. Ops: OR, AND, XOR, pass-A.
- Captures the granted requester's operands, executes in a registered stage, and holds the result until acknowledged.
- Sits between the decode/writeback clients (e.g. flag-mask and immediate-mask paths) and the single physical logic unit, so the unit is never duplicated.

Parameters:
- WIDTH, 16, datapath width of A and result.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0  in  1  requester 0 request; held high with operands stable until gnt0.
- a0  in  WIDTH  requester 0 operand A.
- b0  in  1  requester 0 broadcast bit.
- op0  in  2  requester 0 op: 00 OR, 01 AND, 10 XOR, 11 pass A.
- req1, a1, b1, op1  in  1/WIDTH/1/2  requester 1, same meaning.
- gnt0  out  1  one-cycle grant to requester 0; operands captured on this edge.
- gnt1  out  1  one-cycle grant to requester 1.
- busy  out  1  high whenever state is not IDLE.
- res_vld  out  1  result valid.
- res_id  out  1  owner of the current result (0/1).
- res  out  WIDTH  result data.
- res_ack  in  1  result consumer accepts res; sampled only while res_vld=1.
- wait_cnt  out  16  stall counter (see Optional Feature).

Behaviour:
- States: IDLE, EXEC, DONE.
- IDLE:
  - gnt0/gnt1 are combinational from state, req0/req1 and last_gnt register.
  - Only req0 -> gnt0. Only req1 -> gnt1.
  - Both -> grant the requester not equal to last_gnt.
  - On a grant edge: capture a, b, op into op registers; set owner; update last_gnt; go EXEC.
  - No requests -> stay IDLE.
- EXEC: res <= captured_a op {WIDTH{captured_b}}; res_id <= owner; go DONE.
- DONE:
  - res_vld=1; res and res_id stable.
  - res_ack=1 -> IDLE next cycle, res_vld drops.
  - res_ack=0 -> stay DONE indefinitely.
- Grants occur only in IDLE. Requests arriving in EXEC/DONE wait.
- Latency: grant in cycle T, res_vld in cycle T+2. Minimum issue interval is 3 cycles (ack in first DONE cycle).
- res_ack outside DONE is ignored.
- gnt0 and gnt1 are never both high. gnt is never asserted outside IDLE.
- A req dropped before grant is simply not served (no error).
- Reset (async, rst_n=0), all take effect immediately:
  - state=IDLE, last_gnt=1 (requester 0 wins the first tie).
  - gnt0=gnt1=0, busy=0, res_vld=0, res_id=0, res=0, wait_cnt=0.
- Reset mid-operation discards the in-flight op and result; requesters must re-request.
- Op 11 ignores B. All ops are purely bitwise; no carries, no flags.

Optional Feature:
- Macro: BCAST_LOGIC_WAIT_CNT_EN.
- Defined:
  - wait_cnt is a 16-bit counter, incremented each cycle where state is DONE and res_ack=0.
  - Saturates at 16'hFFFF; cleared only by reset.
- Undefined: wait_cnt tied to 16'h0000 and no counter flops are built.
- Port list is identical in both builds.

Test Plan:
- Single request: req0=1, a0=16'h00F0, b0=1, op0=00 -> gnt0 in T, res_vld in T+2, res=16'hFFFF, res_id=0.
- Op coverage:
  - a1=16'hA5A5, b1=1, op1=01 -> res=16'hA5A5.
  - op1=10 -> res=16'h5A5A.
  - b1=0, op1=00 -> res=16'hA5A5.
  - op1=11, b1=1 -> res=16'hA5A5.
- Simultaneous requests: req0=req1=1 held for 4 ops after reset -> grant order 0,1,0,1. gnt0&gnt1 never both 1.
- Delayed ack: hold res_ack=0 for 5 cycles in DONE -> res/res_vld stable, no new grant despite req1=1, busy=1. Ack -> IDLE, then gnt1.
- Reset mid-op: assert rst_n=0 during EXEC -> res_vld=0, res=0, busy=0 immediately. After release, req re-granted with requester 0 priority.
- With BCAST_LOGIC_WAIT_CNT_EN: ack withheld 7 cycles -> wait_cnt=7. Withheld 70000 cycles -> wait_cnt=16'hFFFF. Without the macro -> wait_cnt=0 throughout.
